// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide serial transmit port between
// NUM_REQ byte-stream requesters. A granted requester keeps the port until
// its packet ends, it drops req_valid, or MAX_BURST bytes have been sent.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; pick next valid requester from rr upward
// ISSUE | owner granted; send its byte once the serial port is not busy
// HOLD  | one cycle after the strobe while tx_busy catches up
// DRAIN | wait for tx_busy low, then release or issue the next byte
module serial_tx_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             ser_tx_data,
  output logic                   ser_new_tx_data,
  input  logic                   ser_tx_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_DRAIN} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   gidx, gidx_nxt;
  logic [IDX_W-1:0]   rr, rr_nxt, rr_after;
  logic [7:0]         cnt, cnt_nxt;
  logic               last_q, last_nxt;
  logic [NUM_REQ-1:0] grant_nxt, ready_nxt;
  logic [7:0]         data_nxt;
  logic               strobe_nxt;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic [7:0]         sel_data;

  assign rr_after = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;

  // First valid requester at or after rr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Byte lane of the current owner.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == IDX_W'(i)) sel_data = req_data[8*i +: 8];
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_nxt  = state;
    gidx_nxt   = gidx;
    rr_nxt     = rr;
    cnt_nxt    = cnt;
    last_nxt   = last_q;
    grant_nxt  = grant;
    ready_nxt  = '0;
    data_nxt   = ser_tx_data;
    strobe_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          gidx_nxt  = pick_idx;
          grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          cnt_nxt   = '0;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!req_valid[gidx]) begin
          grant_nxt = '0;
          rr_nxt    = rr_after;
          state_nxt = S_IDLE;
        end else if (!ser_tx_busy) begin
          data_nxt   = sel_data;
          strobe_nxt = 1'b1;
          ready_nxt  = grant;
          cnt_nxt    = (cnt < MAX_CNT) ? cnt + 8'd1 : cnt;
          last_nxt   = req_last[gidx];
          state_nxt  = S_HOLD;
        end
      end
      S_HOLD: begin
        state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!ser_tx_busy) begin
          if (last_q || cnt == MAX_CNT) begin
            grant_nxt = '0;
            rr_nxt    = rr_after;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      gidx            <= '0;
      rr              <= '0;
      cnt             <= '0;
      last_q          <= 1'b0;
      grant           <= '0;
      req_ready       <= '0;
      ser_tx_data     <= '0;
      ser_new_tx_data <= 1'b0;
    end else begin
      state           <= state_nxt;
      gidx            <= gidx_nxt;
      rr              <= rr_nxt;
      cnt             <= cnt_nxt;
      last_q          <= last_nxt;
      grant           <= grant_nxt;
      req_ready       <= ready_nxt;
      ser_tx_data     <= data_nxt;
      ser_new_tx_data <= strobe_nxt;
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for serial_tx_arbiter: a packet-level round-robin model
// predicts the byte order; a monitor pops and compares on every strobe.
module tb_serial_tx_arbiter;
  localparam int NR = 2;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_valid, req_last, req_ready, grant;
  logic [7:0]      ser_tx_data;
  logic            ser_new_tx_data;
  logic            ser_tx_busy;

  serial_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .ser_tx_data(ser_tx_data), .ser_new_tx_data(ser_new_tx_data),
    .ser_tx_busy(ser_tx_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int model_rr = 0;
  int exp_q[$];
  logic [8:0] rq[NR][$];
  logic [8:0] stage[NR][$];
  bit en[NR];
  int rdy_cnt[NR];
  bit busy_force = 0;
  bit rand_busy = 0;
  int busy_len = 10;
  int busy_rem = 0;
  bit start_pend = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic upd_drv();
    for (int i = 0; i < NR; i++) begin
      if (en[i] && rq[i].size() > 0) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i]       = rq[i][0][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  // Packet-level arbitration: owner sends until last byte or MB bytes.
  task automatic model_push();
    logic [8:0] m[NR][$];
    logic [8:0] b;
    int g, c;
    for (int i = 0; i < NR; i++) m[i] = stage[i];
    while (1) begin
      g = -1;
      for (int k = 0; k < NR; k++) begin
        int idx = (model_rr + k) % NR;
        if (g < 0 && m[idx].size() > 0) g = idx;
      end
      if (g < 0) break;
      c = 0;
      while (1) begin
        b = m[g].pop_front();
        exp_q.push_back(g * 256 + int'(b[7:0]));
        c++;
        if (b[8] || c == MB || m[g].size() == 0) break;
      end
      model_rr = (g + 1) % NR;
    end
  endtask

  task automatic load_stage();
    @(negedge clk);
    model_push();
    for (int i = 0; i < NR; i++) rq[i] = stage[i];
    upd_drv();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    bit done = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && (grant == '0);
      for (int i = 0; i < NR; i++) if (rq[i].size() != 0) done = 0;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic wait_ready(input int idx, input int count, input string name);
    int seen = 0;
    int n = 0;
    while (seen < count && n < 400) begin
      @(negedge clk);
      n++;
      if (req_ready[idx]) seen++;
    end
    chk(name, 32'(seen), 32'(count));
  endtask

  // Requester model: pop on ready, present the next byte at once.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
        if (rst && req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      upd_drv();
    end
  end

  // Serial port model: busy rises the cycle after a strobe.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        busy_rem    = 0;
        start_pend  = 0;
        ser_tx_busy = busy_force;
      end else begin
        if (start_pend) begin
          busy_rem   = rand_busy ? int'($urandom_range(0, 6)) : busy_len;
          start_pend = 0;
        end
        if (ser_new_tx_data) start_pend = 1;
        ser_tx_busy = busy_force || (busy_rem > 0);
        if (busy_rem > 0) busy_rem--;
      end
    end
  end

  // Monitor and scoreboard.
  initial begin
    int e;
    int last_sc = -100;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        chk("ready_matches_strobe", 32'(req_ready), ser_new_tx_data ? 32'(grant) : 32'd0);
        if (ser_new_tx_data) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got data %0h grant %0b expected no strobe", ser_tx_data, grant);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", 32'(ser_tx_data), 32'(e % 256));
            chk("strobe_grant", 32'(grant), 32'(1 << (e / 256)));
          end
          chk("strobe_spacing", 32'((cyc - last_sc) >= 3), 32'd1);
          last_sc = cyc;
          for (int i = 0; i < NR; i++) if (req_ready[i]) rdy_cnt[i]++;
        end
      end else begin
        last_sc = -100;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    rst = 1'b0;
    ser_tx_busy = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    for (int i = 0; i < NR; i++) begin
      en[i] = 1;
      rdy_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_strobe", 32'(ser_new_tx_data), 32'd0);
    chk("reset_data", 32'(ser_tx_data), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single-requester packet, busy 10 cycles per byte.
    stage[0] = '{9'h041, 9'h042, 9'h143};
    stage[1].delete();
    r0 = rdy_cnt[0];
    load_stage();
    wait_idle("single_idle", 400);
    chk("single_ready_count", 32'(rdy_cnt[0] - r0), 32'd3);
    chk("single_release", 32'(grant), 32'd0);

    // Busy lag of one cycle: one strobe per byte.
    busy_len = 1;
    stage[0].delete();
    stage[1] = '{9'h021, 9'h022, 9'h123};
    r0 = rdy_cnt[1];
    load_stage();
    wait_idle("lag_idle", 200);
    chk("lag_ready_count", 32'(rdy_cnt[1] - r0), 32'd3);
    busy_len = 10;

    // Abandoned burst on requester 1.
    @(negedge clk);
    rq[1] = '{9'h010, 9'h011, 9'h012};
    exp_q.push_back(256 + 8'h10);
    exp_q.push_back(256 + 8'h11);
    r0 = rdy_cnt[1];
    upd_drv();
    wait_ready(1, 2, "abandon_two_ready");
    en[1] = 0;
    upd_drv();
    n = 0;
    while (grant != '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abandon_release", 32'(grant), 32'd0);
    repeat (20) @(negedge clk);
    chk("abandon_ready_count", 32'(rdy_cnt[1] - r0), 32'd2);
    rq[1].delete();
    en[1] = 1;
    model_rr = 0;

    // Simultaneous contention.
    stage[0] = '{9'h1A0, 9'h1A1};
    stage[1] = '{9'h1B0, 9'h1B1};
    load_stage();
    wait_idle("contention_idle", 400);

    // Burst limit forces rotation after MB bytes.
    stage[0] = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h106};
    stage[1] = '{9'h1CC};
    load_stage();
    wait_idle("burst_idle", 600);

    // Stuck busy, then release.
    @(negedge clk);
    busy_force = 1;
    ser_tx_busy = 1'b1;
    stage[0] = '{9'h15A};
    stage[1].delete();
    load_stage();
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (ser_new_tx_data) n++;
    end
    chk("stuck_no_strobe", 32'(n), 32'd0);
    chk("stuck_grant_held", 32'(grant), 32'd1);
    busy_force = 0;
    ser_tx_busy = 1'b0;
    @(negedge clk);
    chk("strobe_after_busy_fall", 32'(ser_new_tx_data), 32'd1);
    wait_idle("stuck_idle", 100);

    // Randomized packets with random busy lengths.
    rand_busy = 1;
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NR; i++) begin
        int np;
        stage[i].delete();
        np = int'($urandom_range(0, 2));
        for (int p = 0; p < np; p++) begin
          int len;
          len = int'($urandom_range(1, 7));
          for (int j = 0; j < len; j++) begin
            logic lb;
            logic [7:0] db;
            lb = (j == len - 1);
            db = 8'($urandom);
            stage[i].push_back({lb, db});
          end
        end
      end
      load_stage();
      wait_idle("random_idle", 1500);
    end
    rand_busy = 0;
    busy_len = 10;

    // Reset during DRAIN of the second byte of a five-byte packet.
    @(negedge clk);
    rq[0] = '{9'h060, 9'h061, 9'h062, 9'h063, 9'h164};
    exp_q.push_back(8'h60);
    exp_q.push_back(8'h61);
    upd_drv();
    wait_ready(0, 2, "reset_two_ready");
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    chk("async_rst_strobe", 32'(ser_new_tx_data), 32'd0);
    chk("async_rst_data", 32'(ser_tx_data), 32'd0);
    rq[0].delete();
    upd_drv();
    repeat (3) @(negedge clk);
    chk("reset_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    model_rr = 0;
    stage[0].delete();
    stage[1] = '{9'h177};
    model_push();
    rq[1] = stage[1];
    upd_drv();
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_grant", 32'(grant), 32'd2);
    @(negedge clk);
    chk("post_reset_strobe", 32'(ser_new_tx_data), 32'd1);
    wait_idle("post_reset_idle", 200);

    repeat (5) @(negedge clk);
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
